// File: rtl/mathbox_sequencer.sv
// Math box microcode sequencer: fetches 24-bit PROM microwords and issues one-cycle
// load/accumulate strobes to the matrix processor. It stalls on the MACFLAG handshake.
module mathbox_sequencer #(
  parameter int PC_W      = 10,
  parameter int MAX_STEPS = 1024,
  parameter int MAC_GUARD = 2
) (
  input  logic            clk_12,
  input  logic            reset,
  input  logic            start_wr,
  input  logic [7:0]      start_data,
  output logic [PC_W-1:0] rom_addr,
  input  logic [23:0]     rom_data,
  input  logic            macflag,
  output logic [9:0]      mdb_addr,
  output logic            LDA,
  output logic            LDB,
  output logic            LDC,
  output logic            IP8,
  output logic            CLEARACC,
  output logic            LAC,
  output logic            MATH_RUN,
  output logic            wd_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2} state_t;

  localparam int STEP_W  = $clog2(MAX_STEPS + 1);
  localparam int GUARD_W = (MAC_GUARD > 0) ? $clog2(MAC_GUARD + 1) : 1;

  state_t             state, state_next;
  logic [PC_W-1:0]    pc, pc_next;
  logic [STEP_W-1:0]  step, step_inc;
  logic [GUARD_W-1:0] guard;

  logic       w_halt, w_clracc, w_lda, w_ldb, w_ldc, w_ldacc, w_stacc, w_jump;
  logic [9:0] w_operand;
  logic       unused_rsvd;

  assign w_halt      = rom_data[23];
  assign w_clracc    = rom_data[22];
  assign w_lda       = rom_data[21];
  assign w_ldb       = rom_data[20];
  assign w_ldc       = rom_data[19];
  assign w_ldacc     = rom_data[18];
  assign w_stacc     = rom_data[17];
  assign w_jump      = rom_data[16];
  assign w_operand   = rom_data[9:0];
  assign unused_rsvd = ^rom_data[15:10];

  logic issue, wd_trip, finish;

  // A word issues only when no restart is pending and the processor is free to be loaded.
  assign step_inc = step + STEP_W'(1);
  assign issue    = (state == EXEC) && !start_wr && (guard == '0) && macflag;
  assign wd_trip  = issue && !w_halt && (step_inc == STEP_W'(MAX_STEPS));
  assign finish   = issue && (w_halt || wd_trip);

  always_ff @(posedge clk_12 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_wr) begin
      state_next = FETCH;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        FETCH:   state_next = EXEC;
        EXEC:    if (issue) state_next = finish ? IDLE : FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  logic       lda_d, ldb_d, ldc_d, ip8_d, clr_d, lac_d;
  logic [9:0] mdb_d;

  // A store to RAM takes the bus, so any load requested in the same word is dropped.
  always_comb begin
    clr_d = issue & w_clracc;
    lac_d = issue & w_stacc;
    lda_d = issue & w_lda   & ~w_stacc;
    ldb_d = issue & w_ldb   & ~w_stacc;
    ldc_d = issue & w_ldc   & ~w_stacc;
    ip8_d = issue & w_ldacc & ~w_stacc;
    mdb_d = issue ? w_operand : mdb_addr;
  end

  always_comb begin
    pc_next = pc;
    if (start_wr)   pc_next = PC_W'({start_data, 2'b00});
    else if (issue) pc_next = w_jump ? PC_W'(w_operand) : pc + PC_W'(1);
  end

  // The guard keeps counting across a restart so a MAC already started is still honoured.
  always_ff @(posedge clk_12 or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      step     <= '0;
      guard    <= '0;
      mdb_addr <= '0;
      LDA      <= 1'b0;
      LDB      <= 1'b0;
      LDC      <= 1'b0;
      IP8      <= 1'b0;
      CLEARACC <= 1'b0;
      LAC      <= 1'b0;
      MATH_RUN <= 1'b0;
      wd_err   <= 1'b0;
    end else begin
      pc       <= pc_next;
      mdb_addr <= mdb_d;
      LDA      <= lda_d;
      LDB      <= ldb_d;
      LDC      <= ldc_d;
      IP8      <= ip8_d;
      CLEARACC <= clr_d;
      LAC      <= lac_d;
      if (start_wr)   step <= '0;
      else if (issue) step <= step_inc;
      if (ldc_d)             guard <= GUARD_W'(MAC_GUARD);
      else if (guard != '0) guard <= guard - GUARD_W'(1);
      if (start_wr)    MATH_RUN <= 1'b1;
      else if (finish) MATH_RUN <= 1'b0;
      if (start_wr)     wd_err <= 1'b0;
      else if (wd_trip) wd_err <= 1'b1;
    end
  end

  assign rom_addr = pc;

endmodule
